// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU widths, function codes and unpacker FSM states
package alu_pkg;
  localparam int ALU_N = 4;
  localparam logic [1:0] FN_ADD = 2'b00;
  localparam logic [1:0] FN_OR = 2'b01;
  localparam logic [1:0] FN_AND = 2'b10;
  localparam logic [1:0] FN_CONCAT = 2'b11;
  typedef enum logic [1:0] {IDLE, SEND_HI, SEND_LO} unpack_state_t;
endpackage

// File: rtl/alu_word_unpacker_if.sv
// alu_word_unpacker_if: packed-word input stream and half-word output stream; half_parity exists only with ALU_UNPACK_PARITY_EN
interface alu_word_unpacker_if #(parameter int N = alu_pkg::ALU_N);
  logic [2*N-1:0] packed_in;
  logic in_valid;
  logic in_ready;
  logic [N-1:0] half_out;
  logic half_valid;
  logic half_ready;
  logic half_sel;
  logic last_half;
`ifdef ALU_UNPACK_PARITY_EN
  logic half_parity;
`endif
  modport master(
    output packed_in, in_valid, half_ready,
`ifdef ALU_UNPACK_PARITY_EN
    input half_parity,
`endif
    input in_ready, half_out, half_valid, half_sel, last_half
  );
  modport slave(
    input packed_in, in_valid, half_ready,
`ifdef ALU_UNPACK_PARITY_EN
    output half_parity,
`endif
    output in_ready, half_out, half_valid, half_sel, last_half
  );
endinterface

// File: rtl/alu_word_unpacker_word_fifo.sv
// word_fifo: synchronous power-of-two FIFO exposing its head word and occupancy
module word_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic full,
  output logic empty,
  output logic [AW:0] count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rp, wp;
  always_ff @(posedge clk) if (push) mem[wp] <= wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      rp <= '0;
      wp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
  assign head = mem[rp];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/alu_word_unpacker.sv
// alu_word_unpacker: splits buffered {A,B} words into A then B half-words; ALU_UNPACK_PARITY_EN adds half_parity
module alu_word_unpacker
  import alu_pkg::*;
#(
  parameter int N = ALU_N,
  parameter int DEPTH = 2
) (
  input logic clk,
  input logic rst,
  alu_word_unpacker_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  unpack_state_t state, state_nx;
  logic [2*N-1:0] head;
  logic [CW-1:0] count;
  logic full, empty, accept, push;
  assign accept = bus.half_valid && bus.half_ready;
  assign push = bus.in_valid && !full;
  word_fifo #(.WIDTH(2*N), .DEPTH(DEPTH)) fifo (
    .clk(clk), .rst(rst), .push(push), .pop(accept && state == SEND_LO),
    .wdata(bus.packed_in), .head(head), .full(full), .empty(empty), .count(count)
  );
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  // count == 1 on the final accept means the popped word was the last one queued
  always_comb begin
    state_nx = state == IDLE    ? (empty ? IDLE : SEND_HI)
             : state == SEND_HI ? (accept ? SEND_LO : SEND_HI)
             : accept           ? (count != CW'(1) ? SEND_HI : IDLE)
             :                    SEND_LO;
    bus.half_valid = state != IDLE;
    bus.half_sel = state == SEND_LO;
    bus.last_half = state == SEND_LO;
    bus.half_out = state == SEND_HI ? head[2*N-1:N] : state == SEND_LO ? head[N-1:0] : '0;
    bus.in_ready = !full;
  end
`ifdef ALU_UNPACK_PARITY_EN
  assign bus.half_parity = ^bus.half_out;
`endif
endmodule

// File: tb/tb_alu_word_unpacker.sv
// tb_alu_word_unpacker: directed vectors checked against a queue-based model every cycle
module tb_alu_word_unpacker;
  localparam int N = 4;
  localparam int DEPTH = 2;
  logic clk = 0;
  logic rst = 1;
  alu_word_unpacker_if #(.N(N)) bus();
  alu_word_unpacker #(.N(N), .DEPTH(DEPTH)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc = 0;
  bit armed = 0;
  logic [7:0] q[$];
  int ph = 0;
  logic [3:0] got[$];
  int got_cyc[$];
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [3:0] m_out();
    logic [7:0] w;
    if (ph == 0) return 4'h0;
    w = q[0];
    return ph == 1 ? w[7:4] : w[3:0];
  endfunction
  // model: ph 0 = idle, 1 = upper half shown, 2 = lower half shown
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      q.delete();
      ph = 0;
    end else begin
      automatic int n = q.size();
      automatic bit acc = ph != 0 && bus.half_ready;
      automatic bit pu = bus.in_valid && n < DEPTH;
      if (ph == 0) ph = n != 0 ? 1 : 0;
      else if (ph == 1) ph = acc ? 2 : 1;
      else if (acc) begin
        ph = n - 1 != 0 ? 1 : 0;
        void'(q.pop_front());
      end
      if (pu) q.push_back(bus.packed_in);
    end
  end
  initial forever begin
    @(negedge clk);
    if (armed) begin
      chk("cyc_valid", bus.half_valid, ph != 0);
      chk("cyc_out", bus.half_out, m_out());
      chk("cyc_sel", bus.half_sel, ph == 2);
      chk("cyc_last", bus.last_half, ph == 2);
      chk("cyc_ready", bus.in_ready, q.size() < DEPTH);
`ifdef ALU_UNPACK_PARITY_EN
      chk("cyc_parity", bus.half_parity, ^m_out());
`endif
      if (!rst && bus.half_valid && bus.half_ready) begin
        got.push_back(bus.half_out);
        got_cyc.push_back(cyc);
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    int k = 0;
    while ((bus.half_valid || q.size() != 0) && k < 40) begin
      step();
      k++;
    end
    chk("drain_bound", k < 40, 1);
  endtask
  task automatic expect_seq(string name, int n, logic [31:0] exp);
    chk({name, "_len"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) chk(name, got[i], exp[4*(n-1-i) +: 4]);
    got.delete();
    got_cyc.delete();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.packed_in = '0;
    bus.in_valid = 0;
    bus.half_ready = 0;
    step();
    armed = 1;
    step();
    rst = 0;
    chk("rst_ready", bus.in_ready, 1);
    chk("rst_valid", bus.half_valid, 0);
    chk("rst_out", bus.half_out, 0);
    bus.half_ready = 1;
    bus.packed_in = 8'hA5;
    bus.in_valid = 1;
    step();
    bus.in_valid = 0;
    chk("no_bypass", bus.half_valid, 0);
    step();
    chk("single_hi", {bus.half_valid, bus.half_sel, bus.last_half, bus.half_out}, {3'b100, 4'hA});
    step();
    chk("single_lo", {bus.half_valid, bus.half_sel, bus.last_half, bus.half_out}, {3'b111, 4'h5});
    step();
    chk("single_end", bus.half_valid, 0);
    expect_seq("single", 2, 32'hA5);
    bus.half_ready = 0;
    bus.packed_in = 8'h3C;
    bus.in_valid = 1;
    step();
    bus.in_valid = 0;
    step();
    repeat (3) begin
      chk("bp_hold", {bus.half_valid, bus.half_sel, bus.half_out}, {2'b10, 4'h3});
      step();
    end
    bus.half_ready = 1;
    drain();
    expect_seq("bp", 2, 32'h3C);
    bus.packed_in = 8'h3C;
    bus.in_valid = 1;
    step();
    bus.packed_in = 8'hF0;
    step();
    bus.in_valid = 0;
    drain();
    chk("b2b_nobubble", got_cyc.size() == 4 ? got_cyc[3] - got_cyc[0] : -1, 3);
    expect_seq("b2b", 4, 32'h3CF0);
    bus.half_ready = 0;
    bus.packed_in = 8'h11;
    bus.in_valid = 1;
    step();
    bus.packed_in = 8'h22;
    step();
    bus.packed_in = 8'h33;
    chk("full_ready0", bus.in_ready, 0);
    step();
    step();
    chk("full_hold", bus.in_ready, 0);
    bus.half_ready = 1;
    step();
    chk("full_lo_ready", {bus.in_ready, bus.last_half, bus.half_out}, {2'b01, 4'h1});
    step();
    chk("full_reopen", bus.in_ready, 1);
    step();
    bus.in_valid = 0;
    drain();
    expect_seq("full", 6, 32'h112233);
    bus.half_ready = 0;
    bus.packed_in = 8'h55;
    bus.in_valid = 1;
    step();
    bus.packed_in = 8'h66;
    step();
    bus.in_valid = 0;
    bus.half_ready = 1;
    step();
    bus.half_ready = 0;
    chk("rst_in_lo", {bus.half_valid, bus.last_half, bus.in_ready}, 3'b110);
    rst = 1;
    step();
    rst = 0;
    chk("midrst_valid", bus.half_valid, 0);
    chk("midrst_out", {bus.half_out, bus.half_sel, bus.last_half}, 6'h0);
    chk("midrst_ready", bus.in_ready, 1);
    got.delete();
    got_cyc.delete();
    bus.half_ready = 1;
    bus.packed_in = 8'h96;
    bus.in_valid = 1;
    step();
    bus.in_valid = 0;
    drain();
    expect_seq("after_rst", 2, 32'h96);
`ifdef ALU_UNPACK_PARITY_EN
    bus.packed_in = 8'h73;
    bus.in_valid = 1;
    step();
    bus.in_valid = 0;
    step();
    chk("par_hi", {bus.half_parity, bus.half_out}, {1'b1, 4'h7});
    step();
    chk("par_lo", {bus.half_parity, bus.half_out}, {1'b0, 4'h3});
    drain();
    expect_seq("parity", 2, 32'h73);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_word_unpacker.md
Name: alu_word_unpacker

Overview:
Inverse of the ALU concatenate operation (Function 2'b11 packs {A, B} into a 2N-bit word).
- Accepts packed 2N-bit words over a valid/ready handshake and buffers them in a small FIFO.
- Splits each word back into its upper half (A) and lower half (B).
- Emits the halves one per handshake on an N-bit output stream.
- Sits downstream of the ALU result bus, feeding operand-width consumers.

Parameters:
- N, 4, operand width in bits; packed input width is 2*N.
- DEPTH, 2, number of packed words the FIFO holds; power of two, at least 2.

Ports:
- Clock  input  1  single clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- PackedIn  input  2N  packed word {A, B}.
- InValid  input  1  PackedIn is valid this cycle.
- InReady  output  1  block can accept a word this cycle; equals !full.
- HalfOut  output  N  current half being emitted.
- HalfValid  output  1  HalfOut is valid.
- HalfReady  input  1  consumer accepts HalfOut this cycle.
- HalfSel  output  1  0 = upper half (A), 1 = lower half (B).
- LastHalf  output  1  high while the lower half is presented.

Behaviour:
- Push and pop rules:
  - Push when InValid && InReady.
  - Pop the FIFO head when the lower half is accepted (HalfValid && HalfReady in SEND_LO).
  - No bypass: a word pushed into an empty block is never emitted in the same or next cycle.
- FSM type unpack_state_t: IDLE, SEND_HI, SEND_LO.
  - IDLE -> SEND_HI when count != 0.
  - SEND_HI -> SEND_LO on HalfValid && HalfReady.
  - SEND_LO -> SEND_HI on accept if (count - 1) != 0, otherwise SEND_LO -> IDLE.
  - Otherwise hold the current state.
- Outputs (decoded from the registered state and the FIFO head):
  - HalfValid = (state != IDLE).
  - SEND_HI: HalfOut = head[2N-1:N], HalfSel = 0, LastHalf = 0.
  - SEND_LO: HalfOut = head[N-1:0], HalfSel = 1, LastHalf = 1.
  - IDLE: HalfOut = 0, HalfSel = 0, LastHalf = 0.
- Latency: a word pushed in cycle t into an empty, idle block gives HalfValid in cycle t+2. Steady-state throughput is one half per cycle with no bubble between words.
- Backpressure: while HalfValid && !HalfReady, HalfOut, HalfSel and LastHalf stay stable and the FIFO head is unchanged.
- Full: InReady = 0 when count == DEPTH.
  - A push in the same cycle as a pop at full is not permitted, because InReady is already low.
  - Push and pop in the same cycle when not full: count is unchanged, and read/write pointers each advance.
- Pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits wide.
- Reset, including mid-transfer:
  - Next cycle: state = IDLE, count = 0, pointers = 0.
  - Outputs: HalfValid = 0, HalfOut = 0, HalfSel = 0, LastHalf = 0, InReady = 1.
  - A partially emitted word is discarded.
- No arithmetic on data; halves are pure bit slices.

Optional Feature:
- Macro: ALU_UNPACK_PARITY_EN.
- Defined: adds output port HalfParity (1 bit) = ^HalfOut (even-parity bit, XOR reduction). It is 0 in IDLE and in reset, and is stable under backpressure like HalfOut.
- Undefined: the HalfParity port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package alu_pkg:
  - localparam ALU_N = 4.
  - typedef enum logic [1:0] unpack_state_t {IDLE, SEND_HI, SEND_LO}.
  - Function code constants FN_ADD = 2'b00, FN_OR = 2'b01, FN_AND = 2'b10, FN_CONCAT = 2'b11.
- One sub-module, word_fifo:
  - Parameters WIDTH and DEPTH; synchronous, with push/pop/full/empty/count/head.
  - Instantiated with WIDTH = 2*N.
  - The FSM and output decode stay in alu_word_unpacker.

Test Plan (N=4, DEPTH=2):
- Single word: push 8'hA5, HalfReady=1 -> cycle t+2: HalfOut=4'hA, HalfSel=0; t+3: HalfOut=4'h5, HalfSel=1, LastHalf=1; t+4: HalfValid=0.
- Backpressure: push 8'h3C, hold HalfReady=0 for 3 cycles -> HalfOut stays 4'h3 with HalfSel=0; after release: 4'h3 then 4'hC.
- Back-to-back: push 8'h3C then 8'hF0, HalfReady=1 -> HalfOut sequence 3, C, F, 0 on consecutive cycles, no bubble.
- Full: push 8'h11, 8'h22, 8'h33 with HalfReady=0 -> InReady=0 after the second push. 8'h33 is accepted only in the cycle after the lower half 4'h1 is accepted. Final output order: 1,1,2,2,3,3.
- Reset mid-transfer: assert Reset while in SEND_LO with 2 words queued -> next cycle HalfValid=0, HalfOut=0, InReady=1. A subsequent push of 8'h96 emits 9 then 6.
- Parity (ALU_UNPACK_PARITY_EN defined): push 8'h73 -> HalfParity=1 with 4'h7, then HalfParity=0 with 4'h3.
